// File: rtl/aibnd_red_pkg.sv
// -----------------------------------------------------------------------------
// aibnd_red_pkg
// Shared types and helpers for the AIB redundancy shift controller:
//   - aibnd_red_state_e : sequencing FSM states
//   - aibnd_red_idx_w   : repair index width for a given lane count
//   - aibnd_red_cnt_w   : shared hold/settle counter width
//   - aibnd_red_therm   : index-to-thermometer decode (bit i = i >= idx)
// -----------------------------------------------------------------------------
package aibnd_red_pkg;

  // Widest column supported; the thermometer helper decodes to this width
  // and callers truncate to their own lane count.
  localparam int unsigned AIBND_RED_MAX_IO = 64;

  typedef enum logic [2:0] {
    RED_INIT,
    RED_IDLE,
    RED_RST_ASSERT,
    RED_HOLD,
    RED_SHIFT,
    RED_SETTLE_A,
    RED_SETTLE_D,
    RED_DONE
  } aibnd_red_state_e;

  // Index must also encode NUM_IO itself ("no repair").
  function automatic int unsigned aibnd_red_idx_w(input int unsigned num_io);
    return $clog2(num_io + 1);
  endfunction

  function automatic int unsigned aibnd_red_cnt_w(input int unsigned hold_cyc,
                                                  input int unsigned settle_cyc);
    return $clog2(((hold_cyc > settle_cyc) ? hold_cyc : settle_cyc) + 1);
  endfunction

  function automatic logic [AIBND_RED_MAX_IO-1:0] aibnd_red_therm(input int unsigned idx);
    logic [AIBND_RED_MAX_IO-1:0] v;
    for (int unsigned i = 0; i < AIBND_RED_MAX_IO; i++) begin
      v[i] = (i >= idx);
    end
    return v;
  endfunction

endpackage

// File: rtl/aibnd_red_therm_dec.sv
// -----------------------------------------------------------------------------
// aibnd_red_therm_dec
// Index-to-thermometer decode with a registered output stage. Also used by
// the JTAG readback path.
// Ports:
//   dig_clk, dig_rstb : clock, async active-low reset (outputs clear to 0)
//   load              : capture the decode of idx on this edge
//   idx               : lane index; NUM_IO selects no lane
//   therm             : bit i = 1 when i >= captured index
//   prev_therm        : therm shifted up one lane, bit 0 tied to 0
// -----------------------------------------------------------------------------
module aibnd_red_therm_dec
  import aibnd_red_pkg::*;
#(
  parameter int NUM_IO = 24,
  parameter int IDX_W  = aibnd_red_idx_w(NUM_IO)
) (
  input  logic              dig_clk,
  input  logic              dig_rstb,
  input  logic              load,
  input  logic [IDX_W-1:0]  idx,
  output logic [NUM_IO-1:0] therm,
  output logic [NUM_IO-1:0] prev_therm
);

  logic [NUM_IO-1:0] therm_d;

  assign therm_d = NUM_IO'(aibnd_red_therm({{(32-IDX_W){1'b0}}, idx}));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge dig_clk or negedge dig_rstb) begin
    if (!dig_rstb) begin
      therm <= '0;
    end else if (load) begin
      therm <= therm_d;
    end
  end

  // Each buffer sees its lower neighbour's shift enable.
  assign prev_therm = {therm[NUM_IO-2:0], 1'b0};

endmodule

// File: rtl/aibnd_red_shift_ctrl.sv
// -----------------------------------------------------------------------------
// aibnd_red_shift_ctrl
// Redundancy-repair controller for a column of NUM_IO AIB IO buffers. Turns a
// failing-lane index into the shift_en thermometer and sequences analog and
// digital buffer resets so no buffer changes data path while out of reset.
// Ports:
//   dig_clk, dig_rstb      : clock, async active-low reset
//   repair_vld/repair_rdy  : request handshake (rdy only in IDLE)
//   repair_idx             : first failing lane; NUM_IO = no repair
//   shift_en               : registered, bit i = (i >= active index)
//   prev_io_shift_en       : shift_en[i-1], bit 0 = 0
//   anlg_rstb_out          : analog buffer reset, active-low
//   dig_rstb_out           : digital buffer reset, active-low
//   repair_done            : one-cycle pulse at end of a sequence
//   busy                   : FSM not in IDLE
//   repair_err             : one-cycle pulse on out-of-range index
//                            (only with AIBND_RED_SHIFT_ERRCHK_EN defined)
// Build option: AIBND_RED_SHIFT_ERRCHK_EN rejects indices above NUM_IO;
// without it such indices are clamped to NUM_IO.
// -----------------------------------------------------------------------------
module aibnd_red_shift_ctrl
  import aibnd_red_pkg::*;
#(
  parameter int NUM_IO       = 24,
  parameter int IDX_W        = aibnd_red_idx_w(NUM_IO),
  parameter int RST_HOLD_CYC = 4,
  parameter int SETTLE_CYC   = 8
) (
  input  logic              dig_clk,
  input  logic              dig_rstb,
  input  logic              repair_vld,
  output logic              repair_rdy,
  input  logic [IDX_W-1:0]  repair_idx,
  output logic [NUM_IO-1:0] shift_en,
  output logic [NUM_IO-1:0] prev_io_shift_en,
  output logic              anlg_rstb_out,
  output logic              dig_rstb_out,
  output logic              repair_done,
  output logic              busy
`ifdef AIBND_RED_SHIFT_ERRCHK_EN
  ,
  output logic              repair_err
`endif
);

  localparam int CNT_W = aibnd_red_cnt_w(RST_HOLD_CYC, SETTLE_CYC);

  localparam logic [IDX_W-1:0] IDX_NONE    = IDX_W'(NUM_IO);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  aibnd_red_state_e  state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  req_idx_q, act_idx_q;
  logic              anlg_q, dig_q;
  logic              anlg_d, dig_d;
  logic              cnt_clr, load;
  logic              hs, idx_bad;
  logic [IDX_W-1:0]  idx_in;

  assign hs = repair_vld & (state_q == RED_IDLE);

`ifdef AIBND_RED_SHIFT_ERRCHK_EN
  assign idx_bad = (repair_idx > IDX_NONE);
  assign idx_in  = repair_idx;
`else
  assign idx_bad = 1'b0;
  assign idx_in  = (repair_idx > IDX_NONE) ? IDX_NONE : repair_idx;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    anlg_d  = anlg_q;
    dig_d   = dig_q;
    load    = 1'b0;
    unique case (state_q)
      // INIT uses anlg_q as its phase bit: first count releases analog,
      // second count releases digital and enters IDLE.
      RED_INIT: begin
        if (cnt_q == SETTLE_LAST) begin
          if (!anlg_q) begin
            anlg_d = 1'b1;
          end else begin
            dig_d   = 1'b1;
            state_d = RED_IDLE;
          end
        end
      end
      RED_IDLE: begin
        if (hs && !idx_bad) begin
          if (idx_in == act_idx_q) begin
            state_d = RED_DONE;
          end else begin
            state_d = RED_RST_ASSERT;
            dig_d   = 1'b0;
          end
        end
      end
      RED_RST_ASSERT: begin
        state_d = RED_HOLD;
        anlg_d  = 1'b0;
      end
      RED_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = RED_SHIFT;
      end
      RED_SHIFT: begin
        load    = 1'b1;
        state_d = RED_SETTLE_A;
      end
      RED_SETTLE_A: begin
        if (cnt_q == SETTLE_LAST) begin
          anlg_d  = 1'b1;
          state_d = RED_SETTLE_D;
        end
      end
      RED_SETTLE_D: begin
        if (cnt_q == SETTLE_LAST) begin
          dig_d   = 1'b1;
          state_d = RED_DONE;
        end
      end
      RED_DONE: state_d = RED_IDLE;
      default:  state_d = RED_INIT;
    endcase
  end

  // Shared counter restarts on each state entry and at the INIT phase switch.
  assign cnt_clr = (state_d != state_q) || (state_q == RED_IDLE) ||
                   ((state_q == RED_INIT) && !anlg_q && (cnt_q == SETTLE_LAST));

  always_ff @(posedge dig_clk or negedge dig_rstb) begin
    if (!dig_rstb) begin
      state_q   <= RED_INIT;
      cnt_q     <= '0;
      req_idx_q <= IDX_NONE;
      act_idx_q <= IDX_NONE;
      anlg_q    <= 1'b0;
      dig_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_clr ? '0 : cnt_q + CNT_W'(1);
      anlg_q  <= anlg_d;
      dig_q   <= dig_d;
      if (hs && !idx_bad) req_idx_q <= idx_in;
      if (load)           act_idx_q <= req_idx_q;
    end
  end

  // Decoder captures on the SHIFT exit edge, the same edge act_idx_q loads.
  aibnd_red_therm_dec #(
    .NUM_IO (NUM_IO),
    .IDX_W  (IDX_W)
  ) u_therm_dec (
    .dig_clk    (dig_clk),
    .dig_rstb   (dig_rstb),
    .load       (load),
    .idx        (req_idx_q),
    .therm      (shift_en),
    .prev_therm (prev_io_shift_en)
  );

`ifdef AIBND_RED_SHIFT_ERRCHK_EN
  logic err_q;
  always_ff @(posedge dig_clk or negedge dig_rstb) begin
    if (!dig_rstb) err_q <= 1'b0;
    else           err_q <= hs & idx_bad;
  end
  assign repair_err = err_q;
`endif

  assign anlg_rstb_out = anlg_q;
  assign dig_rstb_out  = dig_q;
  assign repair_rdy    = (state_q == RED_IDLE);
  assign busy          = (state_q != RED_IDLE);
  assign repair_done   = (state_q == RED_DONE);

endmodule

// File: tb/tb_aibnd_red_shift_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aibnd_red_shift_ctrl
// Directed bench for aibnd_red_shift_ctrl with default parameters
// (NUM_IO = 24, RST_HOLD_CYC = 4, SETTLE_CYC = 8). Expected values are
// hand-computed thermometer codes and cycle counts.
// -----------------------------------------------------------------------------
module tb_aibnd_red_shift_ctrl;

  logic        dig_clk = 1'b0;
  logic        dig_rstb = 1'b1;
  logic        repair_vld = 1'b0;
  logic [4:0]  repair_idx = '0;
  logic        repair_rdy;
  logic [23:0] shift_en, prev_io_shift_en;
  logic        anlg_rstb_out, dig_rstb_out, repair_done, busy;
`ifdef AIBND_RED_SHIFT_ERRCHK_EN
  logic        repair_err;
`endif

  int total = 0;
  int bad   = 0;

  // Shift-vs-reset ordering monitor
  bit          mon_en = 1'b0;
  logic [23:0] last_shift = '0;
  int          inv_bad = 0;

  always #5 dig_clk = ~dig_clk;

  aibnd_red_shift_ctrl dut (
    .dig_clk          (dig_clk),
    .dig_rstb         (dig_rstb),
    .repair_vld       (repair_vld),
    .repair_rdy       (repair_rdy),
    .repair_idx       (repair_idx),
    .shift_en         (shift_en),
    .prev_io_shift_en (prev_io_shift_en),
    .anlg_rstb_out    (anlg_rstb_out),
    .dig_rstb_out     (dig_rstb_out),
    .repair_done      (repair_done),
    .busy             (busy)
`ifdef AIBND_RED_SHIFT_ERRCHK_EN
    ,
    .repair_err       (repair_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge dig_clk) begin
    if (mon_en) begin
      if ((shift_en !== last_shift) && (anlg_rstb_out || dig_rstb_out)) inv_bad <= inv_bad + 1;
      last_shift <= shift_en;
    end
  end

  // Release reset and follow the INIT sequence edge by edge.
  task automatic init_seq();
    bit saw_done = 1'b0;
    @(negedge dig_clk);
    dig_rstb = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge dig_clk);
      #1;
      if (repair_done) saw_done = 1'b1;
      if (k == 7) begin
        check("init_anlg_k7", anlg_rstb_out, 1'b0);
        check("init_busy_k7", busy, 1'b1);
      end
      if (k == 8) begin
        check("init_anlg_k8", anlg_rstb_out, 1'b1);
        check("init_dig_k8", dig_rstb_out, 1'b0);
      end
      if (k == 15) begin
        check("init_dig_k15", dig_rstb_out, 1'b0);
        check("init_busy_k15", busy, 1'b1);
        check("init_rdy_k15", repair_rdy, 1'b0);
      end
      if (k == 16) begin
        check("init_dig_k16", dig_rstb_out, 1'b1);
        check("init_busy_k16", busy, 1'b0);
        check("init_rdy_k16", repair_rdy, 1'b1);
        check("init_shift", shift_en, 24'h0);
        check("init_prev", prev_io_shift_en, 24'h0);
      end
    end
    check("init_no_done", saw_done, 1'b0);
  endtask

  // One request; latency = negedges after the handshake edge until done seen.
  task automatic do_repair(input logic [4:0] idx, input bit full, input int exp_lat,
                           input string tag);
    int lat = 0;
    bit rst_dropped = 1'b0;
    @(negedge dig_clk);
    check({tag, "_rdy"}, repair_rdy, 1'b1);
    repair_vld = 1'b1;
    repair_idx = idx;
    @(posedge dig_clk);
    #1;
    repair_vld = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge dig_clk);
      if (!anlg_rstb_out || !dig_rstb_out) rst_dropped = 1'b1;
      if (full && n == 1) begin
        check({tag, "_dig_first"}, dig_rstb_out, 1'b0);
        check({tag, "_anlg_still_hi"}, anlg_rstb_out, 1'b1);
      end
      if (full && n == 2) check({tag, "_anlg_lo"}, anlg_rstb_out, 1'b0);
      if (repair_done) begin
        lat = n;
        break;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_rst_dropped"}, rst_dropped, full);
    @(negedge dig_clk);
    check({tag, "_done_pulse"}, repair_done, 1'b0);
    check({tag, "_rdy_after"}, repair_rdy, 1'b1);
    check({tag, "_anlg_after"}, anlg_rstb_out, 1'b1);
    check({tag, "_dig_after"}, dig_rstb_out, 1'b1);
  endtask

  initial begin
    #3 dig_rstb = 1'b0;
    #1;
    check("rst_shift", shift_en, 24'h0);
    check("rst_prev", prev_io_shift_en, 24'h0);
    check("rst_anlg", anlg_rstb_out, 1'b0);
    check("rst_dig", dig_rstb_out, 1'b0);
    check("rst_rdy", repair_rdy, 1'b0);
    check("rst_done", repair_done, 1'b0);
    check("rst_busy", busy, 1'b1);
    repeat (3) @(posedge dig_clk);
    mon_en = 1'b1;
    init_seq();

    do_repair(5'd5, 1'b1, 23, "idx5");
    check("idx5_shift", shift_en, 24'hFFFFE0);
    check("idx5_prev", prev_io_shift_en, 24'hFFFFC0);

    do_repair(5'd5, 1'b0, 1, "idx5_same");
    check("idx5_same_shift", shift_en, 24'hFFFFE0);

    do_repair(5'd0, 1'b1, 23, "idx0");
    check("idx0_shift", shift_en, 24'hFFFFFF);
    check("idx0_prev", prev_io_shift_en, 24'hFFFFFE);

    do_repair(5'd24, 1'b1, 23, "idx24");
    check("idx24_shift", shift_en, 24'h0);
    check("idx24_prev", prev_io_shift_en, 24'h0);

    do_repair(5'd7, 1'b1, 23, "idx7");
    check("idx7_shift", shift_en, 24'hFFFF80);
    check("idx7_prev", prev_io_shift_en, 24'hFFFF00);

`ifdef AIBND_RED_SHIFT_ERRCHK_EN
    @(negedge dig_clk);
    repair_vld = 1'b1;
    repair_idx = 5'd30;
    @(posedge dig_clk);
    #1;
    repair_vld = 1'b0;
    @(negedge dig_clk);
    check("idx30_err", repair_err, 1'b1);
    check("idx30_rdy", repair_rdy, 1'b1);
    check("idx30_busy", busy, 1'b0);
    @(negedge dig_clk);
    check("idx30_err_pulse", repair_err, 1'b0);
    check("idx30_no_done", repair_done, 1'b0);
    check("idx30_anlg", anlg_rstb_out, 1'b1);
    check("idx30_shift", shift_en, 24'hFFFF80);
`else
    do_repair(5'd30, 1'b1, 23, "idx30");
    check("idx30_shift", shift_en, 24'h0);
    check("idx30_prev", prev_io_shift_en, 24'h0);
`endif

    // Async reset while in SETTLE_A of an idx-9 sequence
    @(negedge dig_clk);
    repair_vld = 1'b1;
    repair_idx = 5'd9;
    @(posedge dig_clk);
    #1;
    repair_vld = 1'b0;
    repeat (10) @(negedge dig_clk);
    check("mid_shift", shift_en, 24'hFFFE00);
    check("mid_anlg", anlg_rstb_out, 1'b0);
    check("mid_busy", busy, 1'b1);
    dig_rstb = 1'b0;
    #1;
    check("arst_shift", shift_en, 24'h0);
    check("arst_prev", prev_io_shift_en, 24'h0);
    check("arst_anlg", anlg_rstb_out, 1'b0);
    check("arst_dig", dig_rstb_out, 1'b0);
    check("arst_busy", busy, 1'b1);
    check("arst_rdy", repair_rdy, 1'b0);
    repeat (2) @(posedge dig_clk);
    init_seq();

    // Active index is back to NUM_IO, so idx 24 is a same-index request.
    do_repair(5'd24, 1'b0, 1, "post_rst_idx24");
    check("post_rst_shift", shift_en, 24'h0);

    check("shift_vs_reset_order", inv_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
